sample_scan_gen: RTL

SAMPLE_SCAN_GEN -- requirements
Module: sample_scan_gen

---
 rtl/sample_scan_gen.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sample_scan_gen.sv
// sample_scan_gen: walks a latched bounding box in x-major raster order at a
// programmable sub-pixel step, emitting one sample position per clock.
module sample_scan_gen #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [1:0][1:0][SIGFIG-1:0]    box_R13S,
  input  logic                                  validBox_R13H,
  input  logic        [3:0]                     subSample_RnnnnU,
  output logic                                  halt_R13L,
  output logic signed [1:0][SIGFIG-1:0]         sample_R16S,
  output logic                                  validSamp_R16H,
  output logic                                  lastSamp_R16H,
  output logic        [31:0]                    sampCount_R16U
);

  // One extra bit of headroom so x+step / y+step never wrap near the maximum.
  localparam int W = SIGFIG + 1;
  typedef logic signed [W-1:0] wide_t;

  typedef enum logic {WAIT, SCAN} state_t;

  state_t      state_reg, state_next;
  logic        halt_reg, halt_next;
  logic        valid_reg, valid_next;
  logic        last_reg, last_next;
  logic [31:0] count_reg, count_next;
  wide_t       x_reg, x_next, y_reg, y_next;
  wide_t       llx_reg, llx_next, ury_reg, ury_next, urx_reg, urx_next;
  wide_t       step_reg, step_next;

  // Sign-extended views of the incoming box corners.
  wide_t in_llx, in_lly, in_urx, in_ury, in_step;
  assign in_llx = W'($signed(box_R13S[0][0]));
  assign in_lly = W'($signed(box_R13S[0][1]));
  assign in_urx = W'($signed(box_R13S[1][0]));
  assign in_ury = W'($signed(box_R13S[1][1]));

  // Decode the one-hot step; anything that is not one-hot means one full pixel.
  always_comb begin
    in_step = wide_t'(1) << RADIX;
    case (subSample_RnnnnU)
      4'b1000: in_step = wide_t'(1) << RADIX;
      4'b0100: in_step = wide_t'(1) << (RADIX - 1);
      4'b0010: in_step = wide_t'(1) << (RADIX - 2);
      4'b0001: in_step = wide_t'(1) << (RADIX - 3);
      default: in_step = wide_t'(1) << RADIX;
    endcase
  end

  wide_t nx, ny, cx, cy;

  // Next-state logic: box acceptance in WAIT, raster advance in SCAN.
  always_comb begin
    state_next = state_reg;
    halt_next  = halt_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    count_next = count_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    llx_next   = llx_reg;
    urx_next   = urx_reg;
    ury_next   = ury_reg;
    step_next  = step_reg;
    nx         = x_reg + step_reg;
    ny         = y_reg + step_reg;
    cx         = x_reg;
    cy         = y_reg;

    case (state_reg)
      WAIT: begin
        valid_next = 1'b0;
        last_next  = 1'b0;
        halt_next  = 1'b1;
        if (validBox_R13H) begin
          llx_next  = in_llx;
          urx_next  = in_urx;
          ury_next  = in_ury;
          step_next = in_step;
          // An inverted box is consumed silently and the block stays idle.
          if ((in_urx >= in_llx) && (in_ury >= in_lly)) begin
            state_next = SCAN;
            halt_next  = 1'b0;
            valid_next = 1'b1;
            x_next     = in_llx;
            y_next     = in_lly;
            last_next  = ((in_llx + in_step) > in_urx) && ((in_lly + in_step) > in_ury);
            count_next = count_reg + 32'd1;
          end
        end
      end
      SCAN: begin
        if (last_reg) begin
          // Final sample is on the outputs now; drop back and reopen the input.
          state_next = WAIT;
          halt_next  = 1'b1;
          valid_next = 1'b0;
          last_next  = 1'b0;
        end else begin
          if (nx <= urx_reg) begin
            cx = nx;
            cy = y_reg;
          end else begin
            cx = llx_reg;
            cy = ny;
          end
          x_next     = cx;
          y_next     = cy;
          valid_next = 1'b1;
          last_next  = ((cx + step_reg) > urx_reg) && ((cy + step_reg) > ury_reg);
          count_next = count_reg + 32'd1;
        end
      end
      default: state_next = WAIT;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= WAIT;
      halt_reg  <= 1'b1;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      count_reg <= 32'd0;
      x_reg     <= '0;
      y_reg     <= '0;
      llx_reg   <= '0;
      urx_reg   <= '0;
      ury_reg   <= '0;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      halt_reg  <= halt_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      count_reg <= count_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      llx_reg   <= llx_next;
      urx_reg   <= urx_next;
      ury_reg   <= ury_next;
      step_reg  <= step_next;
    end
  end

  // Upper bit of the wide position is pure headroom; emitted values stay in range.
  assign sample_R16S[0]  = x_reg[SIGFIG-1:0];
  assign sample_R16S[1]  = y_reg[SIGFIG-1:0];
  assign halt_R13L       = halt_reg;
  assign validSamp_R16H  = valid_reg;
  assign lastSamp_R16H   = last_reg;
  assign sampCount_R16U  = count_reg;

endmodule
